// File: rtl/neuron_pkg.sv
// Shared constants and helpers for the N-input neuron.
package neuron_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  // Arithmetic right shift applied to negative results in the leaky build (slope 1/8).
  localparam int unsigned LEAKY_SHIFT    = 3;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  // Largest signed value representable in width bits.
  function automatic longint sat_max(input int unsigned width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  // Smallest signed value representable in width bits.
  function automatic longint sat_min(input int unsigned width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/neuron_act_sat.sv
// Combinational stage-3 logic: saturate or wrap the biased sum, then apply the activation.
// Build option: NEURON_LEAKY_RELU_EN selects leaky ReLU (slope 1/8) instead of plain ReLU.
module neuron_act_sat import neuron_pkg::*; #(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned SW     = 2 * DEFAULT_DATA_W + 2
) (
  input  logic signed [SW:0]       t,
  input  logic                     sat_mode,
  output logic signed [DATA_W-1:0] f,
  output logic                     ovf
);

  localparam int unsigned TW = SW + 1;
  localparam logic signed [SW:0] T_MAX = TW'(sat_max(DATA_W));
  localparam logic signed [SW:0] T_MIN = TW'(sat_min(DATA_W));

  logic signed [DATA_W-1:0] r;

  // Clamp to the DATA_W signed range in saturate mode, otherwise keep the low bits.
  always_comb begin
    r   = t[DATA_W-1:0];
    ovf = 1'b0;
    if (sat_mode) begin
      if (t > T_MAX) begin
        r   = T_MAX[DATA_W-1:0];
        ovf = 1'b1;
      end else if (t < T_MIN) begin
        r   = T_MIN[DATA_W-1:0];
        ovf = 1'b1;
      end
    end
  end

  // Activation on the post-saturation value.
  always_comb begin
    f = r;
    if (r[DATA_W-1]) begin
`ifdef NEURON_LEAKY_RELU_EN
      f = r >>> LEAKY_SHIFT;
`else
      f = '0;
`endif
    end
  end

endmodule

// File: rtl/neuron_ninput_pipelined.sv
// Three-stage pipelined N-input neuron: multiply, sum, bias+saturate+activation.
// The whole pipeline advances together; a stalled output freezes every stage.
// Build option: NEURON_LEAKY_RELU_EN (handled inside neuron_act_sat).
module neuron_ninput_pipelined import neuron_pkg::*; #(
  parameter int unsigned N_INPUTS       = 4,
  parameter int unsigned DATA_W         = DEFAULT_DATA_W,
  parameter bit          SAT_EN_DEFAULT = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_INPUTS*DATA_W-1:0] x,
  input  logic [N_INPUTS*DATA_W-1:0] w,
  input  logic [DATA_W-1:0]          b,
  input  logic                       sat_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          f,
  output logic                       ovf
);

  localparam int unsigned PW = 2 * DATA_W;
  localparam int unsigned SW = PW + clog2(N_INPUTS);
  localparam int unsigned TW = SW + 1;

  logic                     adv;
  logic                     v1_q, v2_q, v3_q;
  logic signed [PW-1:0]     p_d [N_INPUTS];
  logic signed [PW-1:0]     p_q [N_INPUTS];
  logic signed [DATA_W-1:0] b1_q, b2_q;
  logic                     sat1_q, sat2_q;
  logic signed [SW-1:0]     s_d, s_q;
  logic signed [SW:0]       t;
  logic signed [DATA_W-1:0] f_d, f_q;
  logic                     ovf_d, ovf_q;

  assign adv       = !v3_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = v3_q;
  assign f         = f_q;
  assign ovf       = ovf_q;

  // Full-precision products of each x/w pair.
  always_comb begin
    for (int i = 0; i < N_INPUTS; i++) begin
      p_d[i] = PW'($signed(x[i*DATA_W +: DATA_W])) * PW'($signed(w[i*DATA_W +: DATA_W]));
    end
  end

  // Sign-extended sum of the registered products.
  always_comb begin
    s_d = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      s_d = s_d + SW'(p_q[i]);
    end
  end

  // Bias is added one bit wider than the sum so it cannot overflow before saturation.
  always_comb begin
    t = TW'(s_q) + TW'(b2_q);
  end

  neuron_act_sat #(
    .DATA_W (DATA_W),
    .SW     (SW)
  ) u_act_sat (
    .t        (t),
    .sat_mode (sat2_q),
    .f        (f_d),
    .ovf      (ovf_d)
  );

  // Stage valid bits shift together on advance.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (adv) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  // Stage data registers load only on advance.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_INPUTS; i++) p_q[i] <= '0;
      b1_q   <= '0;
      b2_q   <= '0;
      sat1_q <= SAT_EN_DEFAULT;
      sat2_q <= SAT_EN_DEFAULT;
      s_q    <= '0;
      f_q    <= '0;
      ovf_q  <= 1'b0;
    end else if (adv) begin
      for (int i = 0; i < N_INPUTS; i++) p_q[i] <= p_d[i];
      b1_q   <= b;
      sat1_q <= sat_mode;
      s_q    <= s_d;
      b2_q   <= b1_q;
      sat2_q <= sat1_q;
      f_q    <= f_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: tb/tb_neuron_ninput_pipelined.sv
// Self-checking bench for neuron_ninput_pipelined: directed table, back-pressure,
// async reset, randomized scoreboard run and a small N=1/DATA_W=8 instance.
module tb_neuron_ninput_pipelined;

  localparam int N  = 4;
  localparam int DW = 32;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          in_valid, in_ready, sat_mode, out_valid, out_ready, ovf;
  logic [N*DW-1:0] x, w;
  logic [DW-1:0] b, f;

  logic       in_valid8, in_ready8, sat_mode8, out_valid8, out_ready8, ovf8;
  logic [7:0] x8, w8, b8, f8;

  neuron_ninput_pipelined #(
    .N_INPUTS (N), .DATA_W (DW), .SAT_EN_DEFAULT (1'b1)
  ) dut (
    .clock (clock), .reset (reset), .in_valid (in_valid), .in_ready (in_ready),
    .x (x), .w (w), .b (b), .sat_mode (sat_mode), .out_valid (out_valid),
    .out_ready (out_ready), .f (f), .ovf (ovf)
  );

  neuron_ninput_pipelined #(
    .N_INPUTS (1), .DATA_W (8), .SAT_EN_DEFAULT (1'b1)
  ) dut8 (
    .clock (clock), .reset (reset), .in_valid (in_valid8), .in_ready (in_ready8),
    .x (x8), .w (w8), .b (b8), .sat_mode (sat_mode8), .out_valid (out_valid8),
    .out_ready (out_ready8), .f (f8), .ovf (ovf8)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { logic [DW-1:0] f; logic ovf; } res_t;
  typedef struct {
    string name; logic [N*DW-1:0] x; logic [N*DW-1:0] w; logic [DW-1:0] b;
    logic sat; logic [DW-1:0] f; logic ovf;
  } vec_t;

  res_t sb[$];
  vec_t tbl[8];

  logic          stall_prev;
  logic [DW-1:0] held_f;
  logic          held_ovf;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Reference: exact wide arithmetic, then clamp or wrap, then activation.
  function automatic res_t model(input logic [N*DW-1:0] xb, input logic [N*DW-1:0] wb,
                                 input logic [DW-1:0] bb, input logic sat);
    logic signed [127:0] acc;
    logic signed [DW-1:0] r;
    res_t res;
    acc = 128'sd0;
    for (int i = 0; i < N; i++) begin
      acc = acc + 128'($signed(xb[i*DW +: DW])) * 128'($signed(wb[i*DW +: DW]));
    end
    acc = acc + 128'($signed(bb));
    res.ovf = 1'b0;
    r = acc[DW-1:0];
    if (sat) begin
      if (acc > 128'sd2147483647) begin
        r = 32'sh7FFF_FFFF; res.ovf = 1'b1;
      end else if (acc < -128'sd2147483648) begin
        r = 32'sh8000_0000; res.ovf = 1'b1;
      end
    end
    if (r < 0) begin
`ifdef NEURON_LEAKY_RELU_EN
      r = r >>> 3;
`else
      r = '0;
`endif
    end
    res.f = r;
    return res;
  endfunction

  function automatic vec_t mk(input string name, input logic [N*DW-1:0] xv,
                              input logic [N*DW-1:0] wv, input logic [DW-1:0] bv,
                              input logic sat, input logic [DW-1:0] fv, input logic ov);
    vec_t v;
    v.name = name; v.x = xv; v.w = wv; v.b = bv; v.sat = sat; v.f = fv; v.ovf = ov;
    return v;
  endfunction

  function automatic logic [DW-1:0] rv();
    case ($urandom_range(0, 3))
      0:       return $urandom_range(0, 200) - 100;
      1:       return $urandom;
      2:       return ($urandom_range(0, 1) != 0) ? 32'h4000_0000 : 32'hC000_0000;
      default: return $urandom_range(0, 15);
    endcase
  endfunction

  task automatic rand_bundle();
    for (int i = 0; i < N; i++) begin
      x[i*DW +: DW] = rv();
      w[i*DW +: DW] = rv();
    end
    b = rv();
    sat_mode = 1'($urandom_range(0, 1));
  endtask

  // One clock cycle of handshake with scoreboard checking; entered and left at posedge+1.
  task automatic do_cycle(input logic iv, input logic ordy, output logic acc, output logic drn);
    res_t e;
    if (stall_prev) begin
      check("stall_valid", 64'(out_valid), 64'(1));
      check("stall_f", 64'(f), 64'(held_f));
      check("stall_ovf", 64'(ovf), 64'(held_ovf));
    end
    in_valid = iv;
    out_ready = ordy;
    #1;
    check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
    acc = in_valid && in_ready;
    drn = out_valid && out_ready;
    if (acc) sb.push_back(model(x, w, b, sat_mode));
    if (drn) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_out: got out_valid=1 required no pending result");
      end else begin
        e = sb.pop_front();
        check("sb_f", 64'(f), 64'(e.f));
        check("sb_ovf", 64'(ovf), 64'(e.ovf));
      end
    end
    stall_prev = out_valid && !out_ready;
    held_f = f;
    held_ovf = ovf;
    @(posedge clock); #1;
  endtask

  // Single directed vector with latency check; entered and left at posedge+1.
  task automatic run_vec(input vec_t v);
    int lat;
    x = v.x; w = v.w; b = v.b; sat_mode = v.sat;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({v.name, "_in_ready"}, 64'(in_ready), 64'(1));
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clock); #1;
      lat++;
    end
    check({v.name, "_latency"}, 64'(lat), 64'(3));
    check({v.name, "_f"}, 64'(f), 64'(v.f));
    check({v.name, "_ovf"}, 64'(ovf), 64'(v.ovf));
    @(posedge clock); #1;
    check({v.name, "_once"}, 64'(out_valid), 64'(0));
  endtask

  task automatic run8(input string name, input logic sat, input logic [7:0] ef,
                      input logic eo);
    int lat;
    x8 = 8'h80; w8 = 8'h80; b8 = 8'h00; sat_mode8 = sat;
    in_valid8 = 1'b1; out_ready8 = 1'b1;
    @(posedge clock); #1;
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 10) begin
      @(posedge clock); #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(3));
    check({name, "_f"}, 64'(f8), 64'(ef));
    check({name, "_ovf"}, 64'(ovf8), 64'(eo));
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    logic acc, drn, ordy;
    int sent, drained, stall_left, guard;
    bit seen;

    tbl[0] = mk("basic", {32'd4, 32'd3, 32'd2, 32'd1}, {32'd8, 32'd7, 32'd6, 32'd5},
                32'hFFFF_FFF6, 1'b1, 32'd60, 1'b0);
`ifdef NEURON_LEAKY_RELU_EN
    tbl[1] = mk("negative", {4{32'd1}}, {4{32'hFFFF_FFFB}}, 32'd0, 1'b1, 32'hFFFF_FFFD, 1'b0);
    tbl[4] = mk("sat_neg", {96'd0, 32'h4000_0000}, {96'd0, 32'hC000_0000}, 32'd0, 1'b1,
                32'hF000_0000, 1'b1);
    tbl[5] = mk("wrap_neg", {96'd0, 32'h0001_0000}, {96'd0, 32'h0000_8000}, 32'd0, 1'b0,
                32'hF000_0000, 1'b0);
`else
    tbl[1] = mk("negative", {4{32'd1}}, {4{32'hFFFF_FFFB}}, 32'd0, 1'b1, 32'd0, 1'b0);
    tbl[4] = mk("sat_neg", {96'd0, 32'h4000_0000}, {96'd0, 32'hC000_0000}, 32'd0, 1'b1,
                32'd0, 1'b1);
    tbl[5] = mk("wrap_neg", {96'd0, 32'h0001_0000}, {96'd0, 32'h0000_8000}, 32'd0, 1'b0,
                32'd0, 1'b0);
`endif
    tbl[2] = mk("sat_pos", {96'd0, 32'h4000_0000}, {96'd0, 32'h4000_0000}, 32'd0, 1'b1,
                32'h7FFF_FFFF, 1'b1);
    tbl[3] = mk("trunc", {96'd0, 32'h4000_0000}, {96'd0, 32'h4000_0000}, 32'd0, 1'b0,
                32'd0, 1'b0);
    tbl[6] = mk("bias_clip", {96'd0, 32'h7FFF_FFFF}, {96'd0, 32'd1}, 32'd1, 1'b1,
                32'h7FFF_FFFF, 1'b1);
    tbl[7] = mk("at_max", {96'd0, 32'h7FFF_FFFF}, {96'd0, 32'd1}, 32'd0, 1'b1,
                32'h7FFF_FFFF, 1'b0);

    reset = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; x = '0; w = '0; b = '0; sat_mode = 1'b1;
    in_valid8 = 1'b0; out_ready8 = 1'b1; x8 = '0; w8 = '0; b8 = '0; sat_mode8 = 1'b1;
    stall_prev = 1'b0; held_f = '0; held_ovf = 1'b0;
    #12;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_f", 64'(f), 64'(0));
    check("reset_ovf", 64'(ovf), 64'(0));
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    check("release_in_ready", 64'(in_ready), 64'(1));
    check("release_out_valid", 64'(out_valid), 64'(0));

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // Back-pressure: five bundles, output stalled for four cycles once the first result appears.
    sb.delete(); stall_prev = 1'b0;
    sent = 0; drained = 0; seen = 1'b0; stall_left = 4;
    rand_bundle();
    for (int cyc = 0; cyc < 40 && drained < 5; cyc++) begin
      if (out_valid) seen = 1'b1;
      ordy = 1'b1;
      if (seen && stall_left > 0) begin
        ordy = 1'b0;
        stall_left--;
      end
      do_cycle(sent < 5, ordy, acc, drn);
      if (acc) begin
        sent++;
        rand_bundle();
      end
      if (drn) drained++;
    end
    check("bp_stall_done", 64'(stall_left), 64'(0));
    check("bp_drained", 64'(drained), 64'(5));
    check("bp_sb_empty", 64'(sb.size()), 64'(0));

    // Randomized traffic against the reference model.
    sb.delete(); stall_prev = 1'b0;
    rand_bundle();
    for (int cyc = 0; cyc < 400; cyc++) begin
      do_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, acc, drn);
      if (acc) rand_bundle();
    end
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      do_cycle(1'b0, 1'b1, acc, drn);
      guard++;
    end
    check("rand_sb_empty", 64'(sb.size()), 64'(0));

    // Asynchronous reset with three results in flight.
    sb.delete(); stall_prev = 1'b0;
    for (int k = 0; k < 3; k++) begin
      x = {4{32'd3}}; w = {4{32'd5 + 32'(k)}}; b = 32'd1; sat_mode = 1'b1;
      do_cycle(1'b1, 1'b0, acc, drn);
    end
    check("rst_pre_valid", 64'(out_valid), 64'(1));
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("rst_async_valid", 64'(out_valid), 64'(0));
    check("rst_async_f", 64'(f), 64'(0));
    check("rst_async_ovf", 64'(ovf), 64'(0));
    check("rst_async_in_ready", 64'(in_ready), 64'(1));
    @(negedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    sb.delete(); stall_prev = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("rst_no_stale", 64'(out_valid), 64'(0));
      do_cycle(1'b0, 1'b1, acc, drn);
    end

    // Narrow instance: (-128)*(-128) = 16384.
    run8("n1_sat", 1'b1, 8'h7F, 1'b1);
    run8("n1_wrap", 1'b0, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_ninput_pipelined.md
Name: neuron_ninput_pipelined

Overview:
- Parametrised N-input neuron: f = act(sat(sum_i w[i]*x[i] + b)).
- Three-stage registered pipeline (multiply, sum, bias+saturate+activation) with valid/ready handshake and full-pipeline back-pressure.
- Next-generation replacement for the fixed 2-input neuron; instantiated per neuron inside layer wrappers.

Parameters:
- N_INPUTS, 4, number of x/w pairs (>=1).
- DATA_W, 32, signed width of x, w, b and f.
- SAT_EN_DEFAULT, 1, reset value of saturation mode (1 = saturate, 0 = wrap to DATA_W).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input bundle valid.
- in_ready  out  1  block accepts bundle this cycle.
- x  in  N_INPUTS*DATA_W  packed signed inputs; x[i] = x[i*DATA_W +: DATA_W].
- w  in  N_INPUTS*DATA_W  packed signed weights, same packing.
- b  in  DATA_W  signed bias, sampled together with x/w.
- sat_mode  in  1  1 = saturate, 0 = wrap; sampled with the bundle.
- out_valid  out  1  f valid.
- out_ready  in  1  downstream accepts f.
- f  out  DATA_W  signed activated result.
- ovf  out  1  result clipped by saturation; qualified by out_valid.

Behaviour:
- Reset is asynchronous, active-low. While reset=0: all stage valid bits=0, all data registers=0, f=0, ovf=0, out_valid=0. in_ready=1 the first cycle after release.
- Advance: adv = !out_valid || out_ready. in_ready = adv. All three stages shift together when adv=1 and hold when adv=0. There are no bubbles-collapse; hold is a full-pipeline stall.
- Transfer in: in_valid && in_ready. Stage-1 valid <= in_valid when adv.
- Stage 1: registers p[i] = x[i]*w[i] at 2*DATA_W signed full precision. Also registers b and sat_mode.
- Stage 2: registers s = sign-extended sum of all p[i], width SW = 2*DATA_W + clog2(N_INPUTS) (clog2(1)=0). Carries b and sat_mode.
- Stage 3: t = s + sign-extended b, at SW+1 bits.
  - sat_mode=1: clamp t to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; ovf=1 if clamped.
  - sat_mode=0: take t[DATA_W-1:0]; ovf=0.
  - Activation (ReLU): a negative result gives f=0, otherwise the value passes through. Activation is applied after saturation/truncation.
- Latency: 3 cycles from accepted input to out_valid, with no stalls. Throughput: 1 result per cycle.
- Stall: f, ovf and out_valid hold stable while out_valid && !out_ready.
- Simultaneous accept and drain: allowed (adv=1 when out_ready=1).
- Reset mid-operation: all in-flight results are discarded, with no partial output.
- Data registers load only on adv. Valid bits clear when adv && !prev_valid.

Optional Feature:
- Macro: NEURON_LEAKY_RELU_EN.
- Defined: negative post-saturation value r gives f = r >>> 3 (arithmetic shift, i.e. slope 1/8). Non-negative values pass unchanged.
- Undefined: plain ReLU (negative gives 0). Ports are identical in both builds.

Decomposition:
- Shared package neuron_pkg:
  - DATA_W default.
  - function clog2.
  - Saturation bounds functions sat_max(DATA_W) and sat_min(DATA_W).
  - LEAKY_SHIFT = 3.
- One sub-module: neuron_act_sat.
  - Purely combinational stage-3 logic: SW+1-bit input, sat_mode in; DATA_W-bit f and ovf out.
  - Contains the NEURON_LEAKY_RELU_EN conditional.
  - Instanced once; the top keeps only the pipeline and handshake.

Test Plan:
- Basic (N=4, DATA_W=32): x={1,2,3,4}, w={5,6,7,8}, b=-10, out_ready=1 -> f=60 exactly 3 cycles after accept; ovf=0.
- Negative: x={1,1,1,1}, w={-5,-5,-5,-5}, b=0.
  - Default build: f=0.
  - NEURON_LEAKY_RELU_EN build: f=-3 (-20>>>3).
- Saturation: x[0]=w[0]=32'h4000_0000, rest 0, b=0.
  - sat_mode=1: f=32'h7FFF_FFFF, ovf=1.
  - sat_mode=0: f=0 (truncated), ovf=0.
- Back-pressure: stream 5 bundles back-to-back; hold out_ready=0 for 4 cycles after the first out_valid -> in_ready=0 during the stall, f held, all 5 results emerge in order with none lost or duplicated.
- Async reset: assert reset=0 mid-clock while 3 results are in flight -> out_valid, f and ovf go to 0 immediately (before the next edge); no stale result after release.
- Parametric: N_INPUTS=1, DATA_W=8, x=-128, w=-128, b=0, sat_mode=1 -> f=127, ovf=1.
